// File: rtl/data_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_arb_pkg
//  Description : Shared definitions for the data RAM port-A arbiter:
//                default address/data widths, owner index width and the
//                arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_ram_arb_pkg;

    localparam int c_def_addr_w = 8;    // word address, byte addr[9:2]
    localparam int c_def_data_w = 32;   // RAM data width
    localparam int c_own_w      = 2;    // owner index width (up to 4 requesters)

    typedef enum logic {
        ARB    = 1'b0,                  // round-robin pick every cycle
        LOCKED = 1'b1                   // owner keeps the port while it locks
    } arb_state_t;

endpackage : data_ram_arb_pkg
`default_nettype wire

// File: rtl/data_ram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Round-robin one-hot picker. Scans (i_req & i_mask) starting
//                at i_start and wrapping upward; the first set bit wins.
//  Ports       : i_req   - request vector
//                i_mask  - eligibility mask (1 = may win)
//                i_start - index where the scan begins
//                o_gnt   - one-hot winner
//                o_idx   - winner index
//                o_any   - a winner exists
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import data_ram_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = c_own_w
) (
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_start,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [N-1:0] w_cand;

    assign w_cand = i_req & i_mask;

    // Scan from the far end back towards i_start so the last hit written is
    // the nearest one in round-robin order.
    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(i_start) + k) % N;
            if (w_cand[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_arbiter
//  Description : Shares port A of the synchronous data RAM (1-cycle read
//                latency, byte write enables) between NREQ requesters.
//                Round-robin arbitration with optional locked bursts capped
//                at MAX_BURST grants under contention; read data is returned
//                one cycle after the grant with a per-requester rvalid.
//  Ports       : clk, resetn          - clock, async active-low reset
//                req/lock/wen/addr/wdata - per-requester request fields
//                gnt                  - one-hot access accepted this cycle
//                rvalid/rdata         - read return (one cycle after grant)
//                ram_wea/addra/dina   - to RAM port A
//                ram_douta            - from RAM port A
//                owner                - index of last granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_arbiter
    import data_ram_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = c_def_addr_w,
    parameter int DATA_W    = c_def_data_w,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            lock,
    input  logic [NREQ*(DATA_W/8)-1:0] wen,
    input  logic [NREQ*ADDR_W-1:0]     addr,
    input  logic [NREQ*DATA_W-1:0]     wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic [DATA_W/8-1:0]        ram_wea,
    output logic [ADDR_W-1:0]          ram_addra,
    output logic [DATA_W-1:0]          ram_dina,
    input  logic [DATA_W-1:0]          ram_douta,
    output logic [c_own_w-1:0]         owner
);

    localparam int c_be_w = DATA_W / 8;
    localparam int c_bc_w = $clog2(MAX_BURST + 1);

    generate
        if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
            $error("data_ram_arbiter: NREQ must be in 2..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    arb_state_t          r_state;
    logic [c_own_w-1:0]  r_owner;
    logic [c_bc_w-1:0]   r_burst;
    logic                r_rd_vld;
    logic [c_own_w-1:0]  r_rd_idx;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic [NREQ-1:0]     w_own_oh;
    logic                w_own_req;
    logic                w_others;
    logic                w_cap;
    logic                w_keep;
    logic [NREQ-1:0]     w_mask;
    logic [c_own_w-1:0]  w_start;
    logic [NREQ-1:0]     w_pick_oh;
    logic [c_own_w-1:0]  w_pick_idx;
    logic                w_pick_any;
    logic                w_win_any;
    logic [c_own_w-1:0]  w_win_idx;

    assign w_own_oh  = NREQ'(1) << r_owner;
    assign w_own_req = |(req & w_own_oh);
    assign w_others  = |(req & ~w_own_oh);

    // The burst cap only bites when somebody else is actually waiting.
    assign w_cap     = (r_burst == c_bc_w'(MAX_BURST)) && w_others;
    assign w_keep    = (r_state == LOCKED) && w_own_req && !w_cap;

    // When the cap forces a hand-over, the owner sits out this pick.
    assign w_mask    = ((r_state == LOCKED) && w_cap) ? ~w_own_oh : '1;
    assign w_start   = (r_owner == c_own_w'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (c_own_w)
    ) u_rr_pick (
        .i_req   (req),
        .i_mask  (w_mask),
        .i_start (w_start),
        .o_gnt   (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Grants are held off while reset is asserted.
    assign w_win_any = resetn && (w_keep || w_pick_any);
    assign w_win_idx = w_keep ? r_owner : w_pick_idx;
    assign gnt       = w_win_any ? (w_keep ? w_own_oh : w_pick_oh) : '0;

    // ------------------------------------------------------------------
    // Operand mux towards the RAM (all zero when nobody is granted)
    // ------------------------------------------------------------------
    logic [c_be_w-1:0]   w_win_wen;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_win_lock;

    always_comb begin
        w_win_wen  = '0;
        w_win_addr = '0;
        w_win_data = '0;
        w_win_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_win_wen  = wen[i*c_be_w +: c_be_w];
                w_win_addr = addr[i*ADDR_W +: ADDR_W];
                w_win_data = wdata[i*DATA_W +: DATA_W];
                w_win_lock = lock[i];
            end
        end
    end

    assign ram_wea   = w_win_wen;
    assign ram_addra = w_win_addr;
    assign ram_dina  = w_win_data;

    // ------------------------------------------------------------------
    // Arbiter FSM, owner/burst tracking and read-return pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ARB;
            r_owner  <= c_own_w'(NREQ - 1);
            r_burst  <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= w_win_any && (w_win_wen == '0);
            if (w_win_any) begin
                r_rd_idx <= w_win_idx;
                r_owner  <= w_win_idx;
                if (w_keep) begin
                    r_burst <= (r_burst == c_bc_w'(MAX_BURST)) ? r_burst
                                                               : r_burst + 1'b1;
                end else begin
                    r_burst <= c_bc_w'(1);
                end
                r_state <= w_win_lock ? LOCKED : ARB;
            end else if (r_state == LOCKED && !w_own_req) begin
                r_state <= ARB;
            end
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = r_rd_vld && (r_rd_idx == c_own_w'(i));
        end
    end

    assign rdata = ram_douta;
    assign owner = r_owner;

endmodule : data_ram_arbiter
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_ram_arbiter
//  Description : Directed bench for data_ram_arbiter (NREQ=2, MAX_BURST=4)
//                with a behavioural 1-cycle-latency byte-write RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_arbiter;

    logic        clk;
    logic        resetn;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [7:0]  wen;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic [3:0]  ram_wea;
    logic [7:0]  ram_addra;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    data_ram_arbiter #(
        .NREQ      (2),
        .ADDR_W    (8),
        .DATA_W    (32),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .lock      (lock),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data RAM port A: read-before-write, byte enables.
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h05] = 32'hA5A5A5A5;
        mem[8'h10] = 32'hFFFFFFFF;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) mem[ram_addra][b*8 +: 8] <= ram_dina[b*8 +: 8];
        ram_douta <= mem[ram_addra];
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [31:0] rdata;
        logic [1:0]  owner;
    } vec_t;

    vec_t tbl2 [5];
    vec_t tbl4 [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req = '0; lock = '0; wen = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic run_vec(input string tag, input int i, input vec_t v);
        req  = v.req;
        lock = v.lock;
        @(negedge clk);
        chk($sformatf("%s[%0d] gnt", tag, i), 64'(gnt), 64'(v.gnt));
        chk($sformatf("%s[%0d] rvalid", tag, i), 64'(rvalid), 64'(v.rvalid));
        chk($sformatf("%s[%0d] owner", tag, i), 64'(owner), 64'(v.owner));
        if (v.rvalid != 2'b00)
            chk($sformatf("%s[%0d] rdata", tag, i), 64'(rdata), 64'(v.rdata));
        tick();
    endtask

    initial begin
        //               req    lock   gnt    rvalid rdata          owner
        tbl2[0] = '{2'b11, 2'b00, 2'b01, 2'b00, 32'h0,         2'd1};
        tbl2[1] = '{2'b11, 2'b00, 2'b10, 2'b01, 32'hA5A5A5A5,  2'd0};
        tbl2[2] = '{2'b11, 2'b00, 2'b01, 2'b10, 32'hFFFFFFFF,  2'd1};
        tbl2[3] = '{2'b11, 2'b00, 2'b10, 2'b01, 32'hA5A5A5A5,  2'd0};
        tbl2[4] = '{2'b00, 2'b00, 2'b00, 2'b10, 32'hFFFFFFFF,  2'd1};

        tbl4[0]  = '{2'b11, 2'b01, 2'b01, 2'b00, 32'h0,        2'd1};
        tbl4[1]  = '{2'b11, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[2]  = '{2'b11, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[3]  = '{2'b11, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[4]  = '{2'b11, 2'b01, 2'b10, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[5]  = '{2'b01, 2'b01, 2'b01, 2'b10, 32'hFFFF5678, 2'd1};
        tbl4[6]  = '{2'b01, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[7]  = '{2'b01, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[8]  = '{2'b01, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[9]  = '{2'b01, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[10] = '{2'b01, 2'b01, 2'b01, 2'b01, 32'hA5A5A5A5, 2'd0};
        tbl4[11] = '{2'b00, 2'b00, 2'b00, 2'b01, 32'hA5A5A5A5, 2'd0};

        resetn = 1'b0;
        req = '0; lock = '0; wen = '0; addr = '0; wdata = '0;

        // Reset state
        tick();
        @(negedge clk);
        chk("reset gnt", 64'(gnt), 64'h0);
        chk("reset rvalid", 64'(rvalid), 64'h0);
        chk("reset ram_wea", 64'(ram_wea), 64'h0);
        chk("reset ram_addra", 64'(ram_addra), 64'h0);
        chk("reset ram_dina", 64'(ram_dina), 64'h0);
        chk("reset owner", 64'(owner), 64'd1);
        tick();
        resetn = 1'b1;

        // 1: single read, gnt same cycle, rvalid next cycle
        req = 2'b01; addr = {8'h10, 8'h05};
        @(negedge clk);
        chk("t1 gnt", 64'(gnt), 64'h1);
        chk("t1 ram_addra", 64'(ram_addra), 64'h05);
        chk("t1 ram_wea", 64'(ram_wea), 64'h0);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t1 rvalid", 64'(rvalid), 64'h1);
        chk("t1 rdata", 64'(rdata), 64'hA5A5A5A5);
        chk("t1 gnt idle", 64'(gnt), 64'h0);
        chk("t1 owner", 64'(owner), 64'd0);
        tick();

        // 2: two readers, no lock, alternate from a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) run_vec("t2", i, tbl2[i]);

        // 3: partial write from req1 then read back
        req = 2'b10; wen = {4'b0011, 4'b0000}; wdata = {32'h12345678, 32'h0};
        @(negedge clk);
        chk("t3 gnt", 64'(gnt), 64'h2);
        chk("t3 ram_wea", 64'(ram_wea), 64'h3);
        chk("t3 ram_addra", 64'(ram_addra), 64'h10);
        chk("t3 ram_dina", 64'(ram_dina), 64'h12345678);
        tick();
        req = 2'b10; wen = '0;
        @(negedge clk);
        chk("t3 write no rvalid", 64'(rvalid), 64'h0);
        chk("t3 read gnt", 64'(gnt), 64'h2);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t3 rvalid", 64'(rvalid), 64'h2);
        chk("t3 rdata", 64'(rdata), 64'hFFFF5678);
        tick();

        // 4: locked burst capped at 4 under contention, then unlimited alone
        do_reset();
        for (int i = 0; i < 12; i++) run_vec("t4", i, tbl4[i]);

        // 5: reset right after a read is accepted, with a write pending
        req = 2'b01; lock = 2'b00; wen = '0;
        @(negedge clk);
        chk("t5 gnt", 64'(gnt), 64'h1);
        tick();
        resetn = 1'b0;
        req = 2'b11; wen = {4'hF, 4'h0};
        #1;
        chk("t5 rvalid dropped", 64'(rvalid), 64'h0);
        chk("t5 gnt in reset", 64'(gnt), 64'h0);
        chk("t5 ram_wea in reset", 64'(ram_wea), 64'h0);
        chk("t5 owner in reset", 64'(owner), 64'd1);
        tick();
        chk("t5 rvalid after edge", 64'(rvalid), 64'h0);
        chk("t5 ram_wea after edge", 64'(ram_wea), 64'h0);
        req = 2'b00; wen = '0;
        resetn = 1'b1;
        @(negedge clk);
        chk("t5 gnt released", 64'(gnt), 64'h0);
        tick();

        // 6: idle for 10 cycles after one read by req0
        req = 2'b01;
        @(negedge clk);
        chk("t6 gnt", 64'(gnt), 64'h1);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t6 rvalid", 64'(rvalid), 64'h1);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t6[%0d] gnt", i), 64'(gnt), 64'h0);
            chk($sformatf("t6[%0d] ram_wea", i), 64'(ram_wea), 64'h0);
            chk($sformatf("t6[%0d] rvalid", i), 64'(rvalid), 64'h0);
            chk($sformatf("t6[%0d] owner", i), 64'(owner), 64'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_ram_arbiter
`default_nettype wire
